// File: rtl/snake_body_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : snake_body_sequencer
// Description : Ring buffer of snake body coordinates with self-collision
//               scan. Each game step is serialised into at most two draw
//               commands (erase old tail, paint new head) handed to a
//               downstream pixel painter with a strobe/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_body_sequencer #(
    parameter int                     X_WIDTH     = 5,
    parameter int                     Y_WIDTH     = 5,
    parameter int                     ADDR_WIDTH  = 6,
    parameter int                     LEN_WIDTH   = 7,
    parameter int                     INIT_LEN    = 3,
    parameter int                     COLOR_WIDTH = 8,
    parameter logic [COLOR_WIDTH-1:0] HEAD_COLOR  = 8'h0f,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR    = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_vld,
    input  logic [X_WIDTH-1:0]     head_x,
    input  logic [Y_WIDTH-1:0]     head_y,
    input  logic                   grow,
    output logic                   busy,
    output logic                   collide,
    output logic [LEN_WIDTH-1:0]   length,
    output logic [X_WIDTH-1:0]     o_x,
    output logic [Y_WIDTH-1:0]     o_y,
    output logic [COLOR_WIDTH-1:0] o_color,
    output logic                   o_vld,
    input  logic                   i_done
);

    localparam int                   c_depth     = 1 << ADDR_WIDTH;
    localparam int                   c_ent_w     = X_WIDTH + Y_WIDTH;
    localparam logic [LEN_WIDTH-1:0] c_depth_len = LEN_WIDTH'(c_depth);
    localparam logic [LEN_WIDTH-1:0] c_init_len  = LEN_WIDTH'(INIT_LEN);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_scan   = 3'd1;
    localparam logic [2:0] c_st_tail   = 3'd2;
    localparam logic [2:0] c_st_wait_t = 3'd3;
    localparam logic [2:0] c_st_head   = 3'd4;
    localparam logic [2:0] c_st_wait_h = 3'd5;
    localparam logic [2:0] c_st_dead   = 3'd6;

    logic [c_ent_w-1:0]     r_buf [c_depth];
    logic [2:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_rd_ptr;
    logic [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic [ADDR_WIDTH-1:0]  r_scan_idx;
    logic [LEN_WIDTH-1:0]   r_length;
    logic [LEN_WIDTH-1:0]   r_scan_cnt;
    logic [X_WIDTH-1:0]     r_hx;
    logic [Y_WIDTH-1:0]     r_hy;
    logic                   r_pop;
    logic                   r_collide;
    logic                   r_vld;
    logic [X_WIDTH-1:0]     r_x;
    logic [Y_WIDTH-1:0]     r_y;
    logic [COLOR_WIDTH-1:0] r_color;

    logic                   w_pop;
    logic                   w_match;
    logic [c_ent_w-1:0]     w_tail_entry;

    // A full buffer always pops, so length saturates at the depth and grow is ignored
    assign w_pop        = !(grow || (r_length < c_init_len)) || (r_length == c_depth_len);
    assign w_match      = (r_buf[r_scan_idx] == {r_hx, r_hy});
    assign w_tail_entry = r_buf[r_rd_ptr];

    assign busy    = (r_state != c_st_idle);
    assign collide = r_collide;
    assign length  = r_length;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_color = r_color;
    assign o_vld   = r_vld;

    // Body storage: the new head is committed only once its draw has completed
    always_ff @(posedge clk) begin
        if (!rst && (r_state == c_st_wait_h) && i_done) begin
            r_buf[r_wr_ptr] <= {r_hx, r_hy};
        end
    end

    // Step sequencer: scan for collision, then erase tail / paint head with handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_length   <= '0;
            r_collide  <= 1'b0;
            r_vld      <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
            r_hx       <= '0;
            r_hy       <= '0;
            r_pop      <= 1'b0;
            r_scan_idx <= '0;
            r_scan_cnt <= '0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (step_vld) begin
                        r_hx       <= head_x;
                        r_hy       <= head_y;
                        r_pop      <= w_pop;
                        // The tail cell being freed is skipped by starting one entry later
                        r_scan_idx <= r_rd_ptr + ADDR_WIDTH'(w_pop);
                        r_scan_cnt <= r_length - LEN_WIDTH'(w_pop);
                        r_state    <= c_st_scan;
                    end
                end
                c_st_scan: begin
                    if (r_scan_cnt == '0) begin
                        r_state <= r_pop ? c_st_tail : c_st_head;
                    end else if (w_match) begin
                        r_collide <= 1'b1;
                        r_state   <= c_st_dead;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                        r_scan_cnt <= r_scan_cnt - 1'b1;
                        if (r_scan_cnt == LEN_WIDTH'(1)) begin
                            r_state <= r_pop ? c_st_tail : c_st_head;
                        end
                    end
                end
                c_st_tail: begin
                    r_vld      <= 1'b1;
                    {r_x, r_y} <= w_tail_entry;
                    r_color    <= BG_COLOR;
                    r_state    <= c_st_wait_t;
                end
                c_st_wait_t: begin
                    if (i_done) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_length <= r_length - 1'b1;
                        r_state  <= c_st_head;
                    end
                end
                c_st_head: begin
                    r_vld   <= 1'b1;
                    r_x     <= r_hx;
                    r_y     <= r_hy;
                    r_color <= HEAD_COLOR;
                    r_state <= c_st_wait_h;
                end
                c_st_wait_h: begin
                    if (i_done) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_length <= r_length + 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                c_st_dead: begin
                    r_state <= c_st_dead;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
